// File: rtl/ysyx_23060201_ctrl.sv
// ============================================================================
// ysyx_23060201_ctrl
// ----------------------------------------------------------------------------
// Multi-cycle control sequencer for the single-issue NPC core. Every
// instruction walks IDLE -> FETCH -> DECODE -> EXEC -> [MEM] -> WB -> FETCH.
// A system instruction (ebreak-style, func3 = 000) or any unrecognised opcode
// parks the core in HALT, which only reset leaves.
//
// State encoding (visible on o_state for debug):
//   IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 HALT=6 (7 falls back to IDLE)
//
// Ports:
//   i_clk          core clock
//   i_rst          asynchronous, active-high reset
//   i_inst_op      opcode from decoder, sampled in DECODE
//   i_inst_func3   func3 from decoder, sampled in DECODE
//   i_ifu_rvalid   instruction word available (only honoured in FETCH)
//   i_lsu_done     load/store complete (only honoured in MEM)
//   o_ifu_req      fetch request, held for all of FETCH
//   o_ir_we        latch fetched word into IR (FETCH and i_ifu_rvalid)
//   o_lsu_req      memory access request, held for all of MEM
//   o_lsu_wen      current access is a store
//   o_gpr_we       register-file write enable (WB, writing opcodes only)
//   o_pc_we        PC update enable (WB)
//   o_halt         core stopped (sticky until reset)
//   o_illegal      stop was caused by an illegal instruction (sticky)
//   o_state        current state
//   o_cycle_cnt    active-cycle counter (performance counters only)
//   o_instret_cnt  retired-instruction counter (performance counters only)
//
// Optional feature, macro YSYX_23060201_PERF_CNT_EN:
//   defined   -> 64-bit cycle and instret counters are built; both freeze in
//                HALT and wrap past all-ones.
//   undefined -> no counter registers; both counter outputs are tied to 0.
// ============================================================================
module ysyx_23060201_ctrl #(
    parameter int OP_W = 7,
    parameter int ST_W = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [OP_W-1:0]  i_inst_op,
    input  logic [2:0]       i_inst_func3,
    input  logic             i_ifu_rvalid,
    input  logic             i_lsu_done,
    output logic             o_ifu_req,
    output logic             o_ir_we,
    output logic             o_lsu_req,
    output logic             o_lsu_wen,
    output logic             o_gpr_we,
    output logic             o_pc_we,
    output logic             o_halt,
    output logic             o_illegal,
    output logic [ST_W-1:0]  o_state,
    output logic [63:0]      o_cycle_cnt,
    output logic [63:0]      o_instret_cnt
);

    // ------------------------------------------------------------------------
    // State and opcode definitions
    // ------------------------------------------------------------------------
    typedef enum logic [ST_W-1:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [OP_W-1:0] OP_R   = 7'b0110011;
    localparam logic [OP_W-1:0] OP_I   = 7'b0010011;
    localparam logic [OP_W-1:0] OP_IL  = 7'b0000011;
    localparam logic [OP_W-1:0] OP_S   = 7'b0100011;
    localparam logic [OP_W-1:0] OP_B   = 7'b1100011;
    localparam logic [OP_W-1:0] OP_U   = 7'b0110111;
    localparam logic [OP_W-1:0] OP_UPC = 7'b0010111;
    localparam logic [OP_W-1:0] OP_J   = 7'b1101111;
    localparam logic [OP_W-1:0] OP_JR  = 7'b1100111;
    localparam logic [OP_W-1:0] OP_SYS = 7'b1110011;

    // Opcodes that proceed to EXEC (SYS is handled separately in DECODE).
    function automatic logic f_is_exec_op(input logic [OP_W-1:0] op);
        logic r;
        case (op)
            OP_R, OP_I, OP_IL, OP_S, OP_B,
            OP_U, OP_UPC, OP_J, OP_JR: r = 1'b1;
            default:                   r = 1'b0;
        endcase
        return r;
    endfunction

    // Opcodes that write a result back into the register file.
    function automatic logic f_writes_gpr(input logic [OP_W-1:0] op);
        logic r;
        case (op)
            OP_R, OP_I, OP_IL, OP_U,
            OP_UPC, OP_J, OP_JR: r = 1'b1;
            default:             r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic f_is_mem_op(input logic [OP_W-1:0] op);
        return (op == OP_IL) || (op == OP_S);
    endfunction

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t          r_state;
    logic [OP_W-1:0] r_op_q;
    logic            r_ifu_req;
    logic            r_lsu_req;
    logic            r_lsu_wen;
    logic            r_gpr_we;
    logic            r_pc_we;
    logic            r_halt;
    logic            r_illegal;

    // ------------------------------------------------------------------------
    // Next-state / next-opcode logic
    // ------------------------------------------------------------------------
    state_t          w_state_nxt;
    logic [OP_W-1:0] w_op_nxt;
    logic            w_illegal_nxt;

    always_comb begin
        w_state_nxt   = r_state;
        w_op_nxt      = r_op_q;
        w_illegal_nxt = r_illegal;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (i_ifu_rvalid) begin
                    w_state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                w_op_nxt = i_inst_op;
                if (f_is_exec_op(i_inst_op)) begin
                    w_state_nxt = S_EXEC;
                end else if ((i_inst_op == OP_SYS) && (i_inst_func3 == 3'b000)) begin
                    w_state_nxt = S_HALT;
                end else begin
                    // Unknown opcode, or a SYS flavour this core does not implement.
                    w_state_nxt   = S_HALT;
                    w_illegal_nxt = 1'b1;
                end
            end
            S_EXEC: begin
                w_state_nxt = f_is_mem_op(r_op_q) ? S_MEM : S_WB;
            end
            S_MEM: begin
                if (i_lsu_done) begin
                    w_state_nxt = S_WB;
                end
            end
            S_WB: begin
                w_state_nxt = S_FETCH;
            end
            S_HALT: begin
                w_state_nxt = S_HALT;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State register with registered outputs.
    // Each output is decoded from the *next* state/opcode, so the registered
    // value is exactly the Moore decode of the current state/op_q. The async
    // reset clears the requests in the same cycle reset rises.
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_op_q    <= '0;
            r_ifu_req <= 1'b0;
            r_lsu_req <= 1'b0;
            r_lsu_wen <= 1'b0;
            r_gpr_we  <= 1'b0;
            r_pc_we   <= 1'b0;
            r_halt    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_op_q    <= w_op_nxt;
            r_ifu_req <= (w_state_nxt == S_FETCH);
            r_lsu_req <= (w_state_nxt == S_MEM);
            r_lsu_wen <= (w_state_nxt == S_MEM) && (w_op_nxt == OP_S);
            r_gpr_we  <= (w_state_nxt == S_WB) && f_writes_gpr(w_op_nxt);
            r_pc_we   <= (w_state_nxt == S_WB);
            r_halt    <= (w_state_nxt == S_HALT);
            r_illegal <= w_illegal_nxt;
        end
    end

    assign o_ifu_req = r_ifu_req;
    assign o_lsu_req = r_lsu_req;
    assign o_lsu_wen = r_lsu_wen;
    assign o_gpr_we  = r_gpr_we;
    assign o_pc_we   = r_pc_we;
    assign o_halt    = r_halt;
    assign o_illegal = r_illegal;
    assign o_state   = r_state;

    // IR latch is the one output that must react within the rvalid cycle.
    assign o_ir_we   = i_ifu_rvalid && (r_state == S_FETCH);

    // ------------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------------
`ifdef YSYX_23060201_PERF_CNT_EN
    logic [63:0] r_cycle_cnt;
    logic [63:0] r_instret_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cycle_cnt   <= '0;
            r_instret_cnt <= '0;
        end else begin
            // Counts cycles spent working on instructions; frozen in IDLE/HALT.
            if ((r_state != S_IDLE) && (r_state != S_HALT)) begin
                r_cycle_cnt <= r_cycle_cnt + 64'd1;
            end
            if (r_state == S_WB) begin
                r_instret_cnt <= r_instret_cnt + 64'd1;
            end
        end
    end

    assign o_cycle_cnt   = r_cycle_cnt;
    assign o_instret_cnt = r_instret_cnt;
`else
    assign o_cycle_cnt   = 64'd0;
    assign o_instret_cnt = 64'd0;
`endif

endmodule

// File: doc/ysyx_23060201_ctrl.md
Name: ysyx_23060201_ctrl

Overview:
Multi-cycle sequencer for the single-issue NPC core. Steps each instruction through fetch, decode, execute, memory and writeback. Drives the IFU request, the instruction-register latch, LSU request/write, GPR write-enable and PC update, keyed by the 7-bit opcode and func3 from the decoder. Stops the core permanently on a system instruction or an unknown opcode.

Parameters:
OP_W, 7, opcode width
ST_W, 3, state encoding width

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-high reset
inst_op  in  7  opcode from decoder (valid in DECODE)
inst_func3  in  3  func3 from decoder (valid in DECODE)
ifu_rvalid  in  1  instruction word available
lsu_done  in  1  load/store complete
ifu_req  out  1  fetch request
ir_we  out  1  latch fetched word into IR
lsu_req  out  1  memory access request
lsu_wen  out  1  access is a store
gpr_we  out  1  register-file write enable
pc_we  out  1  PC update enable
halt  out  1  core stopped (sticky)
illegal  out  1  stop caused by unknown opcode (sticky)
state  out  3  current state, for debug
cycle_cnt  out  64  active-cycle counter (optional feature)
instret_cnt  out  64  retired-instruction counter (optional feature)

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6. Value 7 is unreachable and goes to IDLE.
- Reset (asynchronous, any cycle, including mid-MEM or mid-FETCH):
  - state=IDLE, op_q=0.
  - All outputs 0, counters 0.
  - Requests drop in the same cycle reset asserts.
- IDLE: one cycle after reset deasserts, then FETCH.
- FETCH:
  - ifu_req=1 held until ifu_rvalid.
  - In the ifu_rvalid cycle, ir_we=1 (single-cycle pulse); next state DECODE.
  - ifu_rvalid seen in any other state is ignored.
- DECODE: one cycle. inst_op is captured into op_q. Known opcodes:
  - R 0110011, I 0010011, IL 0000011, S 0100011, B 1100011
  - U 0110111, UPC 0010111, J 1101111, JR 1100111
  - SYS 1110011
- DECODE next state:
  - SYS with func3=000: HALT.
  - SYS with other func3: treated as illegal.
  - Unknown opcode: HALT, with illegal=1.
  - Otherwise: EXEC.
- EXEC: one cycle (combinational ALU). op_q is IL or S: MEM; otherwise: WB.
- MEM:
  - lsu_req=1 held until lsu_done; lsu_wen=1 when op_q=S, else 0.
  - lsu_done on the first MEM cycle is legal, so the minimum MEM time is one cycle.
  - On lsu_done, next state WB.
  - lsu_done outside MEM is ignored.
- WB: one cycle.
  - pc_we=1.
  - gpr_we=1 for R, I, IL, U, UPC, J, JR; gpr_we=0 for S and B.
  - Next state FETCH.
- HALT:
  - Absorbing; only reset exits.
  - halt=1; ifu_req, lsu_req, gpr_we, pc_we are all 0.
  - A halting instruction never asserts pc_we or gpr_we.
- Output decoding: all control outputs are Moore decodes of state/op_q, except ir_we (ifu_rvalid AND state=FETCH).
- Latency, with ifu_rvalid in the first FETCH cycle:
  - ALU/branch: 4 cycles (FETCH→DECODE→EXEC→WB).
  - Load/store with immediate lsu_done: 5 cycles.

Optional Feature:
- Macro: YSYX_23060201_PERF_CNT_EN.
- Defined:
  - cycle_cnt increments every cycle the state is not IDLE or HALT.
  - instret_cnt increments on each WB cycle.
  - Both are 64-bit, wrap to 0 past all-ones, and freeze in HALT.
- Undefined: no counter registers are built; cycle_cnt and instret_cnt are tied to 0.

Test Plan:
- Reset, then addi (op 0010011), ifu_rvalid in the first FETCH cycle → state sequence 0,1,2,3,5,1. ir_we pulses once; in WB gpr_we=1 and pc_we=1; instret_cnt=1, cycle_cnt=4 after WB.
- Store (op 0100011), lsu_done delayed 3 cycles → lsu_req and lsu_wen high for exactly 3 MEM cycles, then WB with gpr_we=0, pc_we=1.
- Load (op 0000011), lsu_done in the first MEM cycle → lsu_wen=0, one MEM cycle, WB gpr_we=1. Total 5 cycles per instruction.
- Ebreak (op 1110011, func3 000) → DECODE then HALT; halt=1, illegal=0, no pc_we. ifu_rvalid pulses afterward cause no change and counters stay frozen.
- Opcode 1111111 → HALT with illegal=1. Then rst asserted for 1 cycle → all outputs 0, state=IDLE, counters 0.
- rst asserted mid-MEM with lsu_req=1 → lsu_req falls in the same cycle. After release: IDLE then FETCH; a late lsu_done is ignored.
